// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock flagged FIFO: width derivation and
// elaboration-time parameter legality check.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int ptr_width,
                                        input int afull, input int aempty);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ptr_width == clog2(depth) + 1) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Register-array storage for the FIFO: synchronous write port and a
// registered read port; only the read register is reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wclken,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // NOTE: the array has no reset so it maps onto plain flops/RAM without a
  // reset tree; the pointers alone guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (wclken) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata <= '0;
    else if (rden) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int POINTER_WIDTH = clog2(FIFO_DEPTH) + 1,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     winc,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     rinc,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [POINTER_WIDTH-1:0] fill_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_WIDTH = POINTER_WIDTH - 1;
  localparam logic [POINTER_WIDTH-1:0] AFULL_LVL  = POINTER_WIDTH'(AFULL_THRESH);
  localparam logic [POINTER_WIDTH-1:0] AEMPTY_LVL = POINTER_WIDTH'(AEMPTY_THRESH);
  localparam logic [POINTER_WIDTH-1:0] PTR_ONE    = POINTER_WIDTH'(1);

  if (!fifo_params_ok(FIFO_DEPTH, POINTER_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_flags: illegal depth, pointer width or threshold");
  end

  logic [POINTER_WIDTH-1:0] wptr, rptr;
  logic                     write_en, read_en;
  logic                     overflow_evt, underflow_evt;

  // Full and empty are evaluated on the pre-edge state, so a simultaneous
  // read never frees a slot for the write in the same cycle.
  assign wfull  = (wptr[POINTER_WIDTH-1] != rptr[POINTER_WIDTH-1]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign rempty = (wptr == rptr);
  assign fill_count   = wptr - rptr;
  assign almost_full  = (fill_count >= AFULL_LVL);
  assign almost_empty = (fill_count <= AEMPTY_LVL);

  assign write_en      = winc && !wfull  && !flush;
  assign read_en       = rinc && !rempty && !flush;
  assign overflow_evt  = winc && wfull  && !flush;
  assign underflow_evt = rinc && rempty && !flush;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (write_en) wptr <= wptr + PTR_ONE;
      if (read_en)  rptr <= rptr + PTR_ONE;
    end
  end

  // A fresh error event outranks clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow_evt  || (overflow  && !clr_err);
      underflow <= underflow_evt || (underflow && !clr_err);
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .wclken(write_en),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .rden  (read_en),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock.
Adds the following over the dual-clock FIFO:
- programmable almost-full and almost-empty thresholds
- an exact fill-level count
- sticky overflow and underflow error flags
- a synchronous flush
Sits between the register-file/ALU datapath and the UART TX framer in the system clock domain.

Parameters:
DATA_WIDTH, 8, width of each data word.
FIFO_DEPTH, 8, number of entries; power of two, at least 2.
POINTER_WIDTH, 4, log2(FIFO_DEPTH)+1; the extra MSB is the wrap bit.
AFULL_THRESH, 6, almost_full asserts when fill_count >= this value; range 1..FIFO_DEPTH.
AEMPTY_THRESH, 1, almost_empty asserts when fill_count <= this value; range 0..FIFO_DEPTH-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous active-high reset.
winc  in  1  write request.
wdata  in  DATA_WIDTH  write data, sampled when the write is accepted.
rinc  in  1  read request.
flush  in  1  synchronous empty-the-FIFO command.
clr_err  in  1  clears overflow and underflow.
rdata  out  DATA_WIDTH  read data, registered.
wfull  out  1  FIFO holds FIFO_DEPTH entries.
rempty  out  1  FIFO holds 0 entries.
almost_full  out  1  fill_count >= AFULL_THRESH.
almost_empty  out  1  fill_count <= AEMPTY_THRESH.
fill_count  out  POINTER_WIDTH  current occupancy, 0..FIFO_DEPTH.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high. Assertion takes effect immediately, independent of clk.
- Reset values:
  - write/read pointers = 0, fill_count = 0, rdata = 0
  - wfull = 0, rempty = 1
  - almost_full = 0, almost_empty = 1
  - overflow = 0, underflow = 0
- Memory contents are not reset.
- Write accept: winc && !wfull at the edge. wdata is stored at wptr[POINTER_WIDTH-2:0]; wptr increments.
- Read accept: rinc && !rempty at the edge. rdata <= mem[rptr[POINTER_WIDTH-2:0]] on that edge, so data is valid 1 cycle after the request; rptr increments.
- rdata holds its last value when no read is accepted.
- Pointers wrap naturally modulo 2*FIFO_DEPTH. The wrap bit disambiguates full from empty:
  - full: MSBs differ, remaining bits equal.
  - empty: pointers equal.
- fill_count = wptr - rptr, modulo 2^POINTER_WIDTH.
- All status outputs are decoded from registered pointers only; no combinational path from inputs to outputs.
- Flags and fill_count reflect the new state in the cycle after the accepting edge.
- Simultaneous winc and rinc:
  - Not full and not empty: both accepted; fill_count unchanged.
  - Full: only the read is accepted. The write is refused and sets overflow, because full is evaluated before the read.
  - Empty: only the write is accepted. The read is refused and sets underflow; rdata is unchanged.
- overflow sets on winc && wfull. underflow sets on rinc && rempty.
- clr_err clears both error flags on the next edge. A new error event in the same cycle as clr_err wins, and the flag stays 1.
- flush has priority over winc and rinc:
  - Pointers return to 0 and fill_count becomes 0 on the next edge.
  - Any winc/rinc in the flush cycle is discarded and raises no error.
  - rdata and the error flags are unaffected.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The first write after release is stored at address 0.

Decomposition:
- Package fifo_pkg:
  - clog2 function used to derive POINTER_WIDTH
  - a localparam check function enforcing power-of-two FIFO_DEPTH and legal thresholds
- One sub-module, fifo_mem: a DATA_WIDTH x FIFO_DEPTH register array with
  - one synchronous write port (wclken, waddr, wdata)
  - one registered read port (rden, raddr, rdata)
  - clocked on clk, no reset on the array

Test Plan:
- Reset, then write 8'h11..8'h88 on 8 consecutive cycles, with rinc low throughout:
  - fill_count steps 1..8
  - almost_full rises after the 6th write
  - wfull = 1 after the 8th write
  - overflow stays 0
- From full, pulse winc with 8'hEE:
  - overflow = 1, fill_count stays 8
  - Then read all 8 entries: rdata returns 8'h11..8'h88 in order, each 1 cycle after its rinc; 8'hEE never appears.
  - rempty = 1 after the last read.
- Fill to 4, then assert winc and rinc together for 20 cycles with incrementing data:
  - fill_count holds 4
  - rdata sequence continues without gaps across pointer wrap-around
- Empty FIFO, rinc = 1:
  - underflow = 1, rdata unchanged
  - Same cycle winc = 1 with 8'h5A: fill_count = 1, underflow = 1
  - Next cycle clr_err = 1: underflow = 0
- Fill to 5, assert flush together with winc and rinc:
  - next cycle fill_count = 0, rempty = 1
  - no error flags set
  - next write is read back correctly
- Fill to 3, assert rst asynchronously between clock edges:
  - outputs take reset values immediately, before the next edge
  - after release, write 8'hC3 and read it back: rdata = 8'hC3
